key_count_bcd: RTL and testbench
================================

Name: key_count_bcd

Overview:
Parametrised successor to the two-key counter path: debounces up, down and clear keys and maintains a bounded up/down count. Wrap or saturate mode is selectable. Each new count is converted to packed BCD by a sequential shift-add-3 engine and presented with a valid pulse to the seg7 scan stage. Replaces the filter/count/combinational-B2BCD chain in top-level display designs.

Parameters:
CNT_W, 10, width of the binary count register
DIGITS, 3, number of BCD digits produced; output width is DIGITS*4
MAX_VAL, 999, upper count bound; must satisfy MAX_VAL < 2**CNT_W and MAX_VAL < 10**DIGITS
DEB_CYCLES, 5, stable cycles required before a key level is accepted (5 for sim, 1_000_000 for board)
WRAP, 0, 0 = saturate at 0 / MAX_VAL, 1 = wrap 0<->MAX_VAL

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
key_up  in  1  raw up key, active-low, asynchronous to clk
key_dn  in  1  raw down key, active-low
key_clr  in  1  raw clear key, active-low
count  out  CNT_W  current binary count
bcd  out  DIGITS*4  last completed BCD conversion, most-significant digit in MSBs
bcd_valid  out  1  one-cycle pulse when bcd updates
busy  out  1  high while conversion in progress

Behaviour:
- Reset (rst high at clk edge): count=0, bcd=0, bcd_valid=0, busy=0, debouncers stable=1, pending=0, FSM=IDLE. Reset mid-conversion aborts it; no bcd_valid is issued.
- Debounce, per key: 2-FF synchroniser. Counter increments while the synced level differs from the stable level and clears when they match. At DEB_CYCLES-1 the stable level updates and the counter clears. Press flag pulses for one cycle on stable 1->0 only; release gives no flag. Glitches shorter than DEB_CYCLES are ignored.
- Count update, registered, on the cycle after a flag:
  - clr flag -> 0, overriding everything.
  - up and dn flags together -> no change.
  - up at MAX_VAL -> MAX_VAL if WRAP=0, else 0.
  - dn at 0 -> 0 if WRAP=0, else MAX_VAL.
  - otherwise +1 / -1.
  - clr at count 0 still counts as an update and triggers conversion.
- Conversion FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE -> LOAD when count was updated the previous cycle or pending=1. LOAD latches count into the shift register, zeroes the BCD accumulator, clears pending and sets busy.
  - SHIFT runs exactly CNT_W iterations. Each iteration adds 3 to every digit >= 5, then shifts left 1.
  - DONE writes bcd, pulses bcd_valid, clears busy, then goes to IDLE.
  - Latency: count changes at edge E0; LOAD at E1; SHIFT at E2..E(CNT_W+1); bcd/bcd_valid at E(CNT_W+2). Default is 12 cycles.
- A count update while busy sets pending. Multiple updates collapse to one reconversion of the latest count. bcd always ends equal to BCD(count).
- bcd holds its value between conversions and is never partially updated.

Optional Feature:
- Macro KEY_REPEAT_EN enables auto-repeat on up/dn, gated by localparams HOLD_CYCLES and REPEAT_CYCLES.
- Defined: a key held stable-low for HOLD_CYCLES after its press flag emits an extra flag, then one flag every REPEAT_CYCLES until release. Clear never repeats. Repeat flags obey the same update rules.
- Undefined: exactly one flag per press; repeat counters are absent from the netlist.

Decomposition:
- Package key_count_pkg holds:
  - FSM state typedef conv_state_t {IDLE, LOAD, SHIFT, DONE}
  - BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3
  - function clog2-based shift-counter width helper
- Sub-module key_debounce (params DEB_CYCLES; ports clk, rst, key_in, press) is instantiated three times. The repeat logic lives inside it under KEY_REPEAT_EN.

Test Plan:
- Three clean key_up presses (low 20 cycles each, DEB_CYCLES=5) -> count=3; three bcd_valid pulses; final bcd=12'h003; each bcd_valid 12 cycles after its count edge.
- WRAP=0: key_dn at count 0 -> count stays 0; bcd_valid still pulses with bcd=12'h000. WRAP=1: same press -> count=999, bcd=12'h999. Then key_up -> count=0.
- key_up glitch low for 3 cycles -> no flag, count unchanged, no bcd_valid.
- key_up and key_dn debounced on the same cycle at count=7 -> count=7. key_clr and key_up together -> count=0, bcd=12'h000.
- Two up presses, the second landing mid-conversion (busy=1) from count 9 -> first bcd_valid shows 12'h010 only if the conversion latched 10. Final bcd=12'h011 after one extra conversion. No more than two bcd_valid pulses.
- rst asserted during SHIFT -> next cycle count=0, bcd=0, busy=0, no bcd_valid.

Source files
------------

// File: rtl/key_count_pkg.sv
// Shared types and constants for the debounced key counter with BCD output.
// Holds the conversion FSM states, the shift-add-3 constants and a width helper.
package key_count_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_t;

    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

`ifdef KEY_REPEAT_EN
    localparam int HOLD_CYCLES   = 20;
    localparam int REPEAT_CYCLES = 8;
`endif

    // Bits needed for a counter that runs 0..n-1 (never less than one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key debouncer: 2-FF synchroniser, stability counter, press pulse.
// Ports: clk, rst (sync, active-high), key_in (raw, active-low), press (1-cycle pulse).
// With KEY_REPEAT_EN defined, a held key also emits auto-repeat pulses.
module key_debounce
    import key_count_pkg::*;
#(
    parameter int DEB_CYCLES = 5
`ifdef KEY_REPEAT_EN
    ,
    parameter bit REPEAT = 1'b1
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic press
);

    localparam int DW = cnt_w(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [DW-1:0] deb_cnt;
    logic          accept;
    logic          fall;
    logic          rep_fire;

    // New level accepted this cycle; only a 1->0 change is a press.
    assign accept = (sync_b != stable) && (deb_cnt == DEB_LAST);
    assign fall   = accept && stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a  <= 1'b1;
            sync_b  <= 1'b1;
            stable  <= 1'b1;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            sync_a <= key_in;
            sync_b <= sync_a;
            press  <= fall | rep_fire;
            if (sync_b != stable) begin
                if (accept) begin
                    stable  <= sync_b;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int RMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RW = cnt_w(RMAX);
    localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_cnt;
    logic          rep_phase;
    logic          rep_hit;

    // First interval is the hold delay, then the repeat period.
    assign rep_hit  = rep_phase ? (rep_cnt == REP_LAST) : (rep_cnt == HOLD_LAST);
    assign rep_fire = REPEAT && !stable && rep_hit;

    always_ff @(posedge clk) begin
        if (rst || stable || !REPEAT) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
        end else if (rep_hit) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b1;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/key_count_bcd.sv
// Debounced up/down/clear counter with a sequential shift-add-3 BCD converter.
// Ports: clk, rst (sync, active-high), key_up/key_dn/key_clr (raw, active-low),
//        count (binary), bcd (packed digits, MSD in MSBs), bcd_valid (pulse), busy.
// Optional macro KEY_REPEAT_EN adds auto-repeat on the up and down keys.
module key_count_bcd
    import key_count_pkg::*;
#(
    parameter int CNT_W      = 10,
    parameter int DIGITS     = 3,
    parameter int MAX_VAL    = 999,
    parameter int DEB_CYCLES = 5,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_up,
    input  logic                  key_dn,
    input  logic                  key_clr,
    output logic [CNT_W-1:0]      count,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_VAL);
    localparam int SW = cnt_w(CNT_W);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(CNT_W - 1);

    logic f_up;
    logic f_dn;
    logic f_clr;
    logic upd;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_up (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_up),
        .press (f_up)
    );

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_dn (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_dn),
        .press (f_dn)
    );

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
`ifdef KEY_REPEAT_EN
        ,
        .REPEAT(1'b0)
`endif
    ) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .key_in(key_clr),
        .press (f_clr)
    );

    // Opposing up/down flags cancel and do not request a conversion.
    assign upd = f_clr | (f_up ^ f_dn);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (f_clr) begin
            count <= '0;
        end else if (f_up && !f_dn) begin
            if (count == MAX_C)
                count <= (WRAP != 0) ? '0 : MAX_C;
            else
                count <= count + 1'b1;
        end else if (f_dn && !f_up) begin
            if (count == '0)
                count <= (WRAP != 0) ? MAX_C : '0;
            else
                count <= count - 1'b1;
        end
    end

    conv_state_t          state;
    logic                 pending;
    logic [CNT_W-1:0]     bin_sh;
    logic [DIGITS*4-1:0]  acc;
    logic [DIGITS*4-1:0]  acc_adj;
    logic [SW-1:0]        shift_idx;

    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[d*4 +: 4] >= BCD_ADJ_THRESH)
                acc_adj[d*4 +: 4] = acc[d*4 +: 4] + BCD_ADJ_ADD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= 1'b0;
            bin_sh    <= '0;
            acc       <= '0;
            shift_idx <= '0;
            bcd       <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    // The count register takes the update on this same edge.
                    if (upd || pending)
                        state <= LOAD;
                end
                LOAD: begin
                    bin_sh    <= count;
                    acc       <= '0;
                    shift_idx <= '0;
                    busy      <= 1'b1;
                    // An update landing now is missed by the latch above.
                    pending   <= upd;
                    state     <= SHIFT;
                end
                SHIFT: begin
                    {acc, bin_sh} <= {acc_adj[DIGITS*4-2:0], bin_sh, 1'b0};
                    shift_idx     <= shift_idx + 1'b1;
                    if (upd)
                        pending <= 1'b1;
                    if (shift_idx == SHIFT_LAST)
                        state <= DONE;
                end
                DONE: begin
                    bcd       <= acc;
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    if (upd)
                        pending <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_count_bcd.sv
// Bench for key_count_bcd: table of key presses plus corner-case sequences,
// with bcd results checked through per-instance expectation queues.
module tb_key_count_bcd;

    logic        clk;
    logic        rst;
    logic        a_up, a_dn, a_clr;
    logic [9:0]  a_count;
    logic [11:0] a_bcd;
    logic        a_valid, a_busy;
    logic        b_up, b_dn, b_clr;
    logic [9:0]  b_count;
    logic [11:0] b_bcd;
    logic        b_valid, b_busy;

    key_count_bcd #(
        .CNT_W(10), .DIGITS(3), .MAX_VAL(999), .DEB_CYCLES(5), .WRAP(0)
    ) u_a (
        .clk(clk), .rst(rst), .key_up(a_up), .key_dn(a_dn), .key_clr(a_clr),
        .count(a_count), .bcd(a_bcd), .bcd_valid(a_valid), .busy(a_busy)
    );

    key_count_bcd #(
        .CNT_W(10), .DIGITS(3), .MAX_VAL(999), .DEB_CYCLES(2), .WRAP(1)
    ) u_b (
        .clk(clk), .rst(rst), .key_up(b_up), .key_dn(b_dn), .key_clr(b_clr),
        .count(b_count), .bcd(b_bcd), .bcd_valid(b_valid), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t0 = 0;
    int a_nv = 0;
    int b_nv = 0;
    bit lat_en = 0;
    logic [9:0] a_prev = '0;
    logic [11:0] qa[$];
    logic [11:0] qb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    always @(negedge clk) begin
        if (a_count !== a_prev)
            t0 = cyc;
        a_prev = a_count;
        if (a_valid === 1'b1) begin
            a_nv++;
            if (lat_en)
                check("a_latency", cyc - t0, 12);
            if (qa.size() == 0) begin
                total++;
                bad++;
                $display("FAIL a_unexpected_valid got=%0h want=none", a_bcd);
            end else begin
                check("a_bcd_sb", int'(a_bcd), int'(qa.pop_front()));
            end
        end
        if (b_valid === 1'b1) begin
            b_nv++;
            if (qb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL b_unexpected_valid got=%0h want=none", b_bcd);
            end else begin
                check("b_bcd_sb", int'(b_bcd), int'(qb.pop_front()));
            end
        end
    end

    task automatic press_a(input logic u, d, c, input int low);
        @(negedge clk);
        a_up = ~u; a_dn = ~d; a_clr = ~c;
        repeat (low) @(negedge clk);
        a_up = 1'b1; a_dn = 1'b1; a_clr = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    task automatic press_b(input logic u, d, c, input int low);
        @(negedge clk);
        b_up = ~u; b_dn = ~d; b_clr = ~c;
        repeat (low) @(negedge clk);
        b_up = 1'b1; b_dn = 1'b1; b_clr = 1'b1;
        repeat (25) @(negedge clk);
    endtask

    typedef struct {
        logic u;
        logic d;
        logic c;
        int   exp;
    } vec_t;

    vec_t tv[8];
    int model;
    int prev;
    int nv0;
    bit hit;

    initial begin
        tv[0] = '{1'b1, 1'b0, 1'b0, 1};
        tv[1] = '{1'b1, 1'b0, 1'b0, 2};
        tv[2] = '{1'b1, 1'b0, 1'b0, 3};
        tv[3] = '{1'b0, 1'b1, 1'b0, 2};
        tv[4] = '{1'b0, 1'b0, 1'b1, 0};
        tv[5] = '{1'b0, 1'b1, 1'b0, 0};
        tv[6] = '{1'b0, 1'b0, 1'b1, 0};
        tv[7] = '{1'b1, 1'b0, 1'b0, 1};

        rst = 1'b1;
        a_up = 1'b1; a_dn = 1'b1; a_clr = 1'b1;
        b_up = 1'b1; b_dn = 1'b1; b_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_count", int'(a_count), 0);
        check("rst_bcd", int'(a_bcd), 0);
        check("rst_valid", int'(a_valid), 0);
        check("rst_busy", int'(a_busy), 0);
        check("rst_b_count", int'(b_count), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        model = 0;
        for (int i = 0; i < 8; i++) begin
            prev = model;
            model = tv[i].exp;
            qa.push_back(to_bcd(model));
            lat_en = (model != prev);
            press_a(tv[i].u, tv[i].d, tv[i].c, 20);
            check($sformatf("vec%0d_count", i), int'(a_count), model);
            check($sformatf("vec%0d_bcd", i), int'(a_bcd), int'(to_bcd(model)));
            if (i == 2)
                check("three_valids", a_nv, 3);
        end

        lat_en = 1;
        for (int i = 0; i < 6; i++) begin
            model++;
            qa.push_back(to_bcd(model));
            press_a(1'b1, 1'b0, 1'b0, 20);
        end
        check("count_seven", int'(a_count), 7);

        nv0 = a_nv;
        press_a(1'b1, 1'b1, 1'b0, 20);
        check("updn_count", int'(a_count), 7);
        check("updn_no_valid", a_nv - nv0, 0);

        model = 0;
        qa.push_back(to_bcd(0));
        press_a(1'b1, 1'b0, 1'b1, 20);
        check("clrup_count", int'(a_count), 0);
        check("clrup_bcd", int'(a_bcd), 0);
        lat_en = 0;

        nv0 = a_nv;
        press_a(1'b1, 1'b0, 1'b0, 3);
        check("glitch_count", int'(a_count), 0);
        check("glitch_no_valid", a_nv - nv0, 0);

        qb.push_back(to_bcd(999));
        press_b(1'b0, 1'b1, 1'b0, 8);
        check("wrap_dn_count", int'(b_count), 999);
        check("wrap_dn_bcd", int'(b_bcd), 12'h999);
        qb.push_back(to_bcd(0));
        press_b(1'b1, 1'b0, 1'b0, 8);
        check("wrap_up_count", int'(b_count), 0);
        for (int i = 1; i <= 9; i++) begin
            qb.push_back(to_bcd(i));
            press_b(1'b1, 1'b0, 1'b0, 8);
        end
        check("b_nine", int'(b_count), 9);

        nv0 = b_nv;
        qb.push_back(to_bcd(10));
        qb.push_back(to_bcd(11));
        @(negedge clk);
        b_up = 1'b0;
        repeat (4) @(negedge clk);
        b_up = 1'b1;
        repeat (5) @(negedge clk);
        b_up = 1'b0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (b_count == 10'd11)
                hit = 1;
        end
        check("second_press_seen", int'(hit), 1);
        check("second_while_busy", int'(b_busy), 1);
        b_up = 1'b1;
        repeat (40) @(negedge clk);
        check("collapse_count", int'(b_count), 11);
        check("collapse_bcd", int'(b_bcd), 12'h011);
        check("collapse_valids", b_nv - nv0, 2);

        @(negedge clk);
        a_up = 1'b0;
        hit = 0;
        for (int i = 0; i < 30 && !hit; i++) begin
            @(negedge clk);
            if (a_count == 10'd1)
                hit = 1;
        end
        a_up = 1'b1;
        check("rst_test_press", int'(hit), 1);
        repeat (5) @(negedge clk);
        check("busy_in_shift", int'(a_busy), 1);
        nv0 = a_nv;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_count", int'(a_count), 0);
        check("midrst_bcd", int'(a_bcd), 0);
        check("midrst_busy", int'(a_busy), 0);
        check("midrst_valid", int'(a_valid), 0);
        repeat (20) @(negedge clk);
        check("midrst_no_valid", a_nv - nv0, 0);
        check("midrst_count_hold", int'(a_count), 0);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
